// File: rtl/demorgan_sweep_ctrl_if.sv
// Signal bundle between the De Morgan sweep controller, its test/status side
// and the gate block under test.
interface demorgan_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       drv_a;
  logic       drv_b;
  logic       s_nand;
  logic       s_nanb;
  logic       s_nor;
  logic       s_nandnb;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec;
  logic       fail_valid;

  // Environment side: test/status requester plus the gate block outputs.
  modport master (
    output start, abort, s_nand, s_nanb, s_nor, s_nandnb,
    input  drv_a, drv_b, busy, done, pass, err_cnt, fail_vec, fail_valid
  );

  modport slave (
    input  start, abort, s_nand, s_nanb, s_nor, s_nandnb,
    output drv_a, drv_b, busy, done, pass, err_cnt, fail_vec, fail_valid
  );
endinterface

// File: rtl/demorgan_sweep_ctrl.sv
// Sweeps a two-input De Morgan gate block through all vectors, checks both
// identities plus golden values, and reports pass, error count and first failure.
module demorgan_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  demorgan_sweep_ctrl_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrive  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StCheck  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [3:0] SettleCnt = 4'(SETTLE);
  localparam logic [7:0] PassesCnt = 8'(PASSES);

  logic [2:0] state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic       fail_valid_q, fail_valid_d;
  logic       pass_q, pass_d;
  logic       running;
  logic       mismatch;

  assign running = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);

  // Golden values come from vec_q, which is what drives the block during CHECK.
  assign mismatch = (bus.s_nand != bus.s_nanb) ||
                    (bus.s_nor  != bus.s_nandnb) ||
                    (bus.s_nand != ~(vec_q[1] & vec_q[0])) ||
                    (bus.s_nor  != ~(vec_q[1] | vec_q[0]));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;

    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d      = StDrive;
          vec_d        = 2'd0;
          pass_cnt_d   = 8'd0;
          err_cnt_d    = 8'd0;
          fail_vec_d   = 2'd0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
        end
      end
      StDrive: begin
        settle_cnt_d = SettleCnt;
        state_d      = (SettleCnt == 4'd0) ? StCheck : StSettle;
      end
      StSettle: begin
        settle_cnt_d = settle_cnt_q - 4'd1;
        if (settle_cnt_q <= 4'd1) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        vec_d   = vec_q + 2'd1;
        state_d = StDrive;
        if (vec_q == 2'd3) begin
          pass_cnt_d = pass_cnt_q + 8'd1;
          if (pass_cnt_q + 8'd1 == PassesCnt) begin
            state_d = StDone;
            pass_d  = (err_cnt_d == 8'd0);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides the sequencing but keeps whatever was just recorded.
    if (running && bus.abort) begin
      state_d = StIdle;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vec_q        <= 2'd0;
      pass_cnt_q   <= 8'd0;
      settle_cnt_q <= 4'd0;
      err_cnt_q    <= 8'd0;
      fail_vec_q   <= 2'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.drv_a      = running & vec_q[1];
  assign bus.drv_b      = running & vec_q[0];
  assign bus.busy       = running;
  assign bus.done       = (state_q == StDone);
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Randomized bench for demorgan_sweep_ctrl: three instances with different
// SETTLE/PASSES, a fault-injecting gate model and a run-level reference model.
module tb_demorgan_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       start_v    [3];
  logic       abort_v    [3];
  logic       busy_v     [3];
  logic       done_v     [3];
  logic       pass_v     [3];
  logic       drv_a_v    [3];
  logic       drv_b_v    [3];
  logic       fvalid_v   [3];
  logic [7:0] err_v      [3];
  logic [1:0] fvec_v     [3];
  // Per instance, per {A,B}: bit0 nand, bit1 nanb, bit2 nor, bit3 nandnb inverted.
  logic [3:0][3:0] flip  [3];

  function automatic int unsigned settle_of(input int g);
    case (g)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned passes_of(input int g);
    case (g)
      0:       return 1;
      1:       return 100;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    demorgan_sweep_ctrl_if bus ();
    logic [1:0] ab;
    assign ab           = {bus.drv_a, bus.drv_b};
    assign bus.start    = start_v[g];
    assign bus.abort    = abort_v[g];
    assign bus.s_nand   = ~(bus.drv_a & bus.drv_b) ^ flip[g][ab][0];
    assign bus.s_nanb   = (~bus.drv_a | ~bus.drv_b) ^ flip[g][ab][1];
    assign bus.s_nor    = ~(bus.drv_a | bus.drv_b) ^ flip[g][ab][2];
    assign bus.s_nandnb = (~bus.drv_a & ~bus.drv_b) ^ flip[g][ab][3];
    assign busy_v[g]    = bus.busy;
    assign done_v[g]    = bus.done;
    assign pass_v[g]    = bus.pass;
    assign drv_a_v[g]   = bus.drv_a;
    assign drv_b_v[g]   = bus.drv_b;
    assign fvalid_v[g]  = bus.fail_valid;
    assign err_v[g]     = bus.err_cnt;
    assign fvec_v[g]    = bus.fail_vec;

    demorgan_sweep_ctrl #(
      .SETTLE(settle_of(g)),
      .PASSES(passes_of(g))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: what the gate block presents for vector v, judged by the four rules.
  function automatic bit vec_bad(input int g, input logic [1:0] v);
    logic a, b, g_nand, g_nor, o_nand, o_nanb, o_nor, o_nandnb;
    a        = v[1];
    b        = v[0];
    g_nand   = !(a && b);
    g_nor    = !(a || b);
    o_nand   = g_nand ^ flip[g][v][0];
    o_nanb   = (!a || !b) ^ flip[g][v][1];
    o_nor    = g_nor ^ flip[g][v][2];
    o_nandnb = (!a && !b) ^ flip[g][v][3];
    return (o_nand != o_nanb) || (o_nor != o_nandnb) || (o_nand != g_nand) || (o_nor != g_nor);
  endfunction

  // Full run with the expected outcome derived from the vector-by-vector model.
  task automatic run_check(input int g, input bit hold_start, input bit b2b, input string tag);
    int unsigned per, exp_busy, exp_err, busy_n, drv_bad, cyc;
    bit          exp_fvalid, seen;
    logic [1:0]  exp_fvec;
    per        = 2 + settle_of(g);
    exp_busy   = passes_of(g) * 4 * per;
    exp_err    = 0;
    exp_fvalid = 0;
    exp_fvec   = 2'd0;
    for (int p = 0; p < int'(passes_of(g)); p++) begin
      for (int v = 0; v < 4; v++) begin
        if (vec_bad(g, 2'(v))) begin
          if (!exp_fvalid) begin
            exp_fvalid = 1;
            exp_fvec   = 2'(v);
          end
          if (exp_err < 255) exp_err++;
        end
      end
    end
    busy_n  = 0;
    drv_bad = 0;
    cyc     = 0;
    seen    = 0;
    if (!b2b) @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    if (!hold_start) start_v[g] = 1'b0;
    while (!seen && cyc < exp_busy + 100) begin
      if (busy_v[g]) begin
        if ({drv_a_v[g], drv_b_v[g]} != 2'((busy_n / per) % 4)) drv_bad++;
        busy_n++;
      end
      if (done_v[g]) begin
        seen = 1;
        check_eq({tag, "/done_quiet"}, {busy_v[g], drv_a_v[g], drv_b_v[g]}, 0);
        check_eq({tag, "/pass"}, pass_v[g], (exp_err == 0));
      end
      cyc++;
      if (!seen) @(negedge clk);
    end
    start_v[g] = 1'b0;
    check_eq({tag, "/done_seen"}, seen, 1);
    check_eq({tag, "/busy_cycles"}, busy_n, exp_busy);
    check_eq({tag, "/drv_seq_errs"}, drv_bad, 0);
    check_eq({tag, "/err_cnt"}, err_v[g], exp_err);
    check_eq({tag, "/fail_valid"}, fvalid_v[g], exp_fvalid);
    check_eq({tag, "/fail_vec"}, fvec_v[g], exp_fvec);
    @(negedge clk);
    check_eq({tag, "/done_pulse"}, done_v[g], 0);
    check_eq({tag, "/pass_held"}, pass_v[g], (exp_err == 0));
  endtask

  // Abort raised during busy cycle k (1-based); CHECKs completing by then are recorded.
  task automatic abort_check(input int g, input int unsigned k, input string tag);
    int unsigned per, busy_n, exp_err, done_n;
    bit          exp_fvalid;
    logic [1:0]  exp_fvec;
    per        = 2 + settle_of(g);
    exp_err    = 0;
    exp_fvalid = 0;
    exp_fvec   = 2'd0;
    for (int unsigned j = 0; (j + 1) * per <= k; j++) begin
      if (vec_bad(g, 2'(j % 4))) begin
        if (!exp_fvalid) begin
          exp_fvalid = 1;
          exp_fvec   = 2'(j % 4);
        end
        exp_err++;
      end
    end
    busy_n = 0;
    @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    for (int c = 0; c < 100 && busy_n < k; c++) begin
      if (busy_v[g]) busy_n++;
      if (busy_n < k) @(negedge clk);
    end
    check_eq({tag, "/reached"}, busy_n, k);
    abort_v[g] = 1'b1;
    @(negedge clk);
    abort_v[g] = 1'b0;
    check_eq({tag, "/idle_quiet"}, {busy_v[g], drv_a_v[g], drv_b_v[g], done_v[g]}, 0);
    check_eq({tag, "/pass"}, pass_v[g], 0);
    check_eq({tag, "/err_cnt"}, err_v[g], exp_err);
    check_eq({tag, "/fail_valid"}, fvalid_v[g], exp_fvalid);
    check_eq({tag, "/fail_vec"}, fvec_v[g], exp_fvec);
    done_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_v[g] || busy_v[g]) done_n++;
    end
    check_eq({tag, "/stays_idle"}, done_n, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned busy_n;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      abort_v[g] = 1'b0;
      flip[g]    = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("reset%0d", g), {busy_v[g], done_v[g], pass_v[g], drv_a_v[g],
               drv_b_v[g], fvalid_v[g], err_v[g], fvec_v[g]}, 0);
    end
    rst_n = 1'b1;

    run_check(0, 0, 0, "clean");

    for (int v = 0; v < 3; v++) flip[0][v] = 4'b0001;
    run_check(0, 0, 0, "nand_sa0");

    for (int v = 1; v < 4; v++) flip[1][v] = 4'b0100;
    run_check(1, 0, 0, "nor_sa1_sat");
    flip[1] = '0;

    flip[0]    = '0;
    flip[0][0] = 4'b0010;
    abort_check(0, 5, "abort5");
    flip[0]    = '0;
    run_check(0, 0, 0, "after_abort");
    flip[0][0] = 4'b1000;
    flip[0][1] = 4'b0001;
    abort_check(0, 6, "abort_in_check");
    flip[0]    = '0;

    // Asynchronous reset during SETTLE of vector 01, with one error already logged.
    flip[2][0] = 4'b0001;
    busy_n     = 0;
    @(negedge clk);
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    for (int c = 0; c < 100 && busy_n < 8; c++) begin
      if (busy_v[2]) busy_n++;
      if (busy_n < 8) @(negedge clk);
    end
    check_eq("pre_reset_err", err_v[2], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset", {busy_v[2], done_v[2], pass_v[2], drv_a_v[2], drv_b_v[2],
             fvalid_v[2], err_v[2], fvec_v[2]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", {busy_v[2], done_v[2]}, 0);
    flip[2] = '0;
    run_check(2, 0, 0, "post_reset_run");

    flip[0][2] = 4'b0110;
    run_check(0, 1, 0, "start_held");
    flip[0] = '0;

    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("start_abort_idle%0d", c), busy_v[0], 0);
    end
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;

    for (int r = 0; r < 10; r++) begin
      int g;
      g = int'($urandom_range(0, 2));
      for (int v = 0; v < 4; v++) begin
        flip[g][v] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      run_check(g, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                $sformatf("rand%0d_g%0d", r, g));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demorgan_sweep_ctrl.md
# demorgan_sweep_ctrl

Self-checking sequencer for the two-input De Morgan gate block. It drives the block's A/B inputs through every input combination for a configurable number of sweeps and waits a settle time before sampling the NAND, NOR, nA|nB and nA&nB results. It checks both De Morgan identities and the golden truth values, then reports pass/fail, a saturating mismatch count and the first failing vector. It sits between a test/status interface and one gate-block instance.

## Interface
- SETTLE, default 1: wait cycles between driving a vector and sampling it; legal range 0..15.
- PASSES, default 1: number of full 4-vector sweeps per run; legal range 1..255.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled in IDLE only
- abort  in  1  cancel run; sampled in any state
- drv_a  out  1  A input to gate block
- drv_b  out  1  B input to gate block
- s_nand  in  1  gate block not(A and B)
- s_nanb  in  1  gate block (not A) or (not B)
- s_nor  in  1  gate block not(A or B)
- s_nandnb  in  1  gate block (not A) and (not B)
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  run result, valid from done until the next accepted start
- err_cnt  out  8  mismatching vectors this run, saturating at 255
- fail_vec  out  2  {A,B} of the first mismatching vector
- fail_valid  out  1  fail_vec holds a captured vector

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- Internal counters:
  - vec: 2 bits, order 00, 01, 10, 11.
  - pass_cnt: 8 bits.
  - settle_cnt: 4 bits.
- IDLE:
  - drv_a/drv_b are 0.
  - start=1 and abort=0 → DRIVE.
  - On an accepted start: clear err_cnt, fail_vec, fail_valid, pass, vec and pass_cnt.
- DRIVE (1 cycle):
  - {drv_a,drv_b} = vec.
  - Load settle_cnt = SETTLE.
  - Next state is SETTLE, or CHECK when SETTLE = 0.
- SETTLE:
  - drv held; decrement settle_cnt.
  - → CHECK when settle_cnt reaches 1.
  - Total time in SETTLE is exactly SETTLE cycles.
- CHECK (1 cycle): the vector mismatches when any of these is true:
  - s_nand != s_nanb
  - s_nor != s_nandnb
  - s_nand != ~(drv_a & drv_b)
  - s_nor != ~(drv_a | drv_b)
- On a mismatch:
  - err_cnt increments by 1 per vector, holding at 255.
  - If fail_valid=0, capture fail_vec = vec and set fail_valid = 1.
- Leaving CHECK:
  - vec increments, wrapping 11 → 00.
  - On a wrap, pass_cnt increments; if pass_cnt+1 == PASSES → DONE, else → DRIVE.
  - Without a wrap → DRIVE.
- DONE (1 cycle):
  - done=1, busy=0, drv=00.
  - pass = (err_cnt == 0), registered and then held.
  - → IDLE.
- busy = 1 in DRIVE, SETTLE and CHECK.
- abort=1 in DRIVE, SETTLE or CHECK:
  - Next edge → IDLE; drv=00, busy=0, no done, pass=0.
  - err_cnt, fail_vec and fail_valid keep their values.
  - A mismatch in the abort cycle is still recorded.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Reset:
  - rst_n=0 forces IDLE immediately with no clock edge required.
  - All outputs become 0: drv_a, drv_b, busy, done, pass, err_cnt, fail_vec, fail_valid.
  - All counters become 0.
  - Applies equally mid-run.

## Timing
- A start accepted at edge E0 gives DRIVE for vec 00 in the cycle after E0; busy and drv are registered and valid in that cycle.
- Each vector takes 2+SETTLE cycles.
- busy is high for PASSES × 4 × (2+SETTLE) cycles, followed by one DONE cycle with done=1.
- err_cnt and fail_vec update on the edge ending CHECK, so they are visible the next cycle.
- pass is visible in the DONE cycle and held afterwards.
- Gate-block outputs are sampled only in CHECK, so no combinational path exists from the s_* inputs to any output.
- Back-to-back runs: start may be accepted in the first IDLE cycle after DONE.

## Test plan
- SETTLE=1, PASSES=1, correct gate model, start pulse:
  - busy high exactly 12 cycles.
  - drv sequence 00, 01, 10, 11, each held 3 cycles.
  - done pulses once; pass=1, err_cnt=0, fail_valid=0.
- s_nand stuck at 0, PASSES=1:
  - Mismatches at vectors 00, 01 and 10.
  - err_cnt=3, fail_vec=2'b00, fail_valid=1, pass=0.
- s_nor stuck at 1, PASSES=100, SETTLE=0:
  - 3 mismatches per pass (01, 10, 11) saturate err_cnt at 255.
  - fail_vec=2'b01; busy lasts 800 cycles.
- Abort in the 5th busy cycle:
  - busy=0 and drv=00 the next cycle; no done.
  - A following start clears the counters and completes a clean run with pass=1.
- rst_n pulled low mid-SETTLE between clock edges: all outputs read 0 before the next clk edge; FSM is in IDLE after release.
- start held during a run has no effect on duration or results. start and abort asserted together in IDLE leave busy=0 for the following 3 cycles.
